alu_operand_stage: RTL and testbench

//  Upstream issue stage for the ALU. Accepts encoded instructions over a valid/ready handshake and reads

---
 rtl/alu_operand_stage.sv | 194 +++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: issue stage that reads operands from a small signed register file,
//   drives them to an external ALU and writes the ALU result back.
// Latency: ALU ops: accept -> ALU_LATENCY cycles in ISSUE -> 1 cycle WRITEBACK; LDI: accept -> WRITEBACK.
// Backpressure: instr_ready_out is high only in IDLE, so one instruction is in flight at a time.
//
// Ports:
//   clock_in, reset_in                      clock, asynchronous active-high reset
//   instr_valid_in/instr_ready_out/instr_in instruction handshake, instr = {opcode, dst, src1, src2, imm}
//   alu_enable_out, alu_opcode_out,
//   alu_input1_out, alu_input2_out          ALU request, held stable outside ISSUE
//   alu_result_in                           ALU answer, sampled on the last ISSUE edge only
//   result_valid_out/result_dst_out/result_out  one-cycle writeback report, dst/value held afterwards
//   error_out                               illegal-opcode pulse
//
// Build option: define ALU_OPERAND_STAGE_ILLEGAL_TRAP_EN to trap opcodes 5..14 instead of issuing them.

module alu_operand_stage #(
  parameter int DATA_WIDTH   = 4,
  parameter int OPCODE_WIDTH = 4,
  parameter int REG_COUNT    = 4,
  parameter int ALU_LATENCY  = 1,
  localparam int ADDR_W      = $clog2(REG_COUNT),
  localparam int INSTR_W     = OPCODE_WIDTH + 3 * ADDR_W + DATA_WIDTH
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    instr_valid_in,
  output logic                    instr_ready_out,
  input  logic [INSTR_W-1:0]      instr_in,
  output logic                    alu_enable_out,
  output logic [OPCODE_WIDTH-1:0] alu_opcode_out,
  output logic [DATA_WIDTH-1:0]   alu_input1_out,
  output logic [DATA_WIDTH-1:0]   alu_input2_out,
  input  logic [DATA_WIDTH-1:0]   alu_result_in,
  output logic                    result_valid_out,
  output logic [ADDR_W-1:0]       result_dst_out,
  output logic [DATA_WIDTH-1:0]   result_out,
  output logic                    error_out
);

  // Counter is sized for the full legal ALU_LATENCY range (1..15).
  localparam int CNT_W = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDI     = '1;
  localparam logic [OPCODE_WIDTH-1:0] OP_LAST_OK = OPCODE_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Instruction fields
  logic [OPCODE_WIDTH-1:0] f_op;
  logic [ADDR_W-1:0]       f_dst;
  logic [ADDR_W-1:0]       f_src1;
  logic [ADDR_W-1:0]       f_src2;
  logic [DATA_WIDTH-1:0]   f_imm;

  assign f_imm  = instr_in[DATA_WIDTH-1:0];
  assign f_src2 = instr_in[DATA_WIDTH +: ADDR_W];
  assign f_src1 = instr_in[DATA_WIDTH + ADDR_W +: ADDR_W];
  assign f_dst  = instr_in[DATA_WIDTH + 2 * ADDR_W +: ADDR_W];
  assign f_op   = instr_in[INSTR_W-1 -: OPCODE_WIDTH];

  logic accept;
  logic op_is_ldi;
  logic op_is_alu;

  assign accept    = instr_valid_in && (state == S_IDLE);
  assign op_is_ldi = (f_op == OP_LDI);

`ifdef ALU_OPERAND_STAGE_ILLEGAL_TRAP_EN
  logic op_is_illegal;
  assign op_is_illegal = !op_is_ldi && (f_op > OP_LAST_OK);
  assign op_is_alu     = !op_is_ldi && !op_is_illegal;
`else
  // Undefined opcodes are handed to the ALU like any other operation.
  assign op_is_alu     = !op_is_ldi;
`endif

  // Datapath state
  logic [DATA_WIDTH-1:0]   regs [REG_COUNT];
  logic [CNT_W-1:0]        cnt;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [ADDR_W-1:0]       dst_q;
  logic [DATA_WIDTH-1:0]   in1_q;
  logic [DATA_WIDTH-1:0]   in2_q;
  logic [ADDR_W-1:0]       res_dst_q;
  logic [DATA_WIDTH-1:0]   res_q;

  logic issue_go;
  logic issue_done;

  assign issue_go   = accept && op_is_alu;
  assign issue_done = (state == S_ISSUE) && (cnt == '0);

  // State register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op_is_ldi) begin
            state_nxt = S_WB;
          end else if (op_is_alu) begin
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_TRAP;
          end
        end
      end
      S_ISSUE: begin
        if (cnt == '0) begin
          state_nxt = S_WB;
        end
      end
      S_WB:    state_nxt = S_IDLE;
      S_TRAP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, latency counter, register file and result capture.
  // Operands are read combinationally at accept; the previous writeback has
  // always landed by then, so no forwarding is needed.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      cnt       <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      res_dst_q <= '0;
      res_q     <= '0;
    end else begin
      if (issue_go) begin
        op_q  <= f_op;
        dst_q <= f_dst;
        in1_q <= regs[f_src1];
        in2_q <= regs[f_src2];
        cnt   <= CNT_W'(ALU_LATENCY - 1);
      end else if ((state == S_ISSUE) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      // alu_result_in is only looked at on the final ISSUE edge.
      if (issue_done) begin
        regs[dst_q] <= alu_result_in;
        res_q       <= alu_result_in;
        res_dst_q   <= dst_q;
      end

      if (accept && op_is_ldi) begin
        regs[f_dst] <= f_imm;
        res_q       <= f_imm;
        res_dst_q   <= f_dst;
      end
    end
  end

  // Outputs
  assign instr_ready_out  = (state == S_IDLE);
  assign alu_enable_out   = (state == S_ISSUE);
  assign alu_opcode_out   = op_q;
  assign alu_input1_out   = in1_q;
  assign alu_input2_out   = in2_q;
  assign result_valid_out = (state == S_WB);
  assign result_dst_out   = res_dst_q;
  assign result_out       = res_q;

`ifdef ALU_OPERAND_STAGE_ILLEGAL_TRAP_EN
  assign error_out = (state == S_TRAP);
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed + randomized bench for alu_operand_stage with a combinational ALU.
// Latency: default ALU_LATENCY=1 (ALU op: pulse 2 cycles after accept; LDI: 1 cycle).
// Backpressure: instr_valid is held high through not-ready cycles in the streaming section.

module tb_alu_operand_stage;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [13:0] instr;
  logic        alu_en;
  logic [3:0]  alu_op;
  logic [3:0]  alu_in1;
  logic [3:0]  alu_in2;
  logic [3:0]  alu_res;
  logic        res_vld;
  logic [1:0]  res_dst;
  logic [3:0]  res_val;
  logic        err;
  logic [3:0]  noise;

  int vectors;
  int miscompares;
  int m [4];   // reference register file

  alu_operand_stage dut (
    .clock_in         (clk),
    .reset_in         (rst),
    .instr_valid_in   (instr_valid),
    .instr_ready_out  (instr_ready),
    .instr_in         (instr),
    .alu_enable_out   (alu_en),
    .alu_opcode_out   (alu_op),
    .alu_input1_out   (alu_in1),
    .alu_input2_out   (alu_in2),
    .alu_result_in    (alu_res),
    .result_valid_out (res_vld),
    .result_dst_out   (res_dst),
    .result_out       (res_val),
    .error_out        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU stand-in; outside ISSUE it returns noise that must be ignored.
  function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'd0:    alu_fn = a + b;
      4'd1:    alu_fn = a - b;
      4'd2:    alu_fn = a * b;
      4'd3:    alu_fn = {3'b0, a == b};
      4'd4:    alu_fn = {3'b0, $signed(a) > $signed(b)};
      default: alu_fn = a ^ b;
    endcase
  endfunction

  always @(*) begin
    if (alu_en) alu_res = alu_fn(alu_op, alu_in1, alu_in2);
    else        alu_res = noise;
  end

  always @(negedge clk) noise = 4'($urandom);

  // Reference result from plain integer arithmetic on 4-bit two's complement values.
  function automatic int ref_res(input int op, input int a, input int b, input int imm);
    int sa, sb;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    case (op)
      0:       return (a + b) & 15;
      1:       return (a - b) & 15;
      2:       return (a * b) & 15;
      3:       return (a == b) ? 1 : 0;
      4:       return (sa > sb) ? 1 : 0;
      15:      return imm & 15;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit is_trap(input int op);
`ifdef ALU_OPERAND_STAGE_ILLEGAL_TRAP_EN
    return (op >= 5) && (op <= 14);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE (called at a negedge) and check every cycle until ready returns.
  task automatic issue(input int op, input int dst, input int s1, input int s2, input int imm);
    int a, b, r;
    a = m[s1];
    b = m[s2];
    r = ref_res(op, a, b, imm);
    chk("ready_before_accept", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {op[3:0], dst[1:0], s1[1:0], s2[1:0], imm[3:0]};
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 14'($urandom);
    if (op == 15) begin
      chk("ldi_pulse", res_vld, 1);
      chk("ldi_dst", res_dst, dst);
      chk("ldi_val", res_val, r);
      chk("ldi_no_alu", alu_en, 0);
      chk("ldi_busy", instr_ready, 0);
      m[dst] = r;
      @(negedge clk);
      chk("ldi_pulse_end", res_vld, 0);
      chk("ldi_ready_back", instr_ready, 1);
      chk("ldi_val_hold", res_val, r);
    end else if (is_trap(op)) begin
      chk("trap_err", err, 1);
      chk("trap_no_alu", alu_en, 0);
      chk("trap_no_pulse", res_vld, 0);
      chk("trap_busy", instr_ready, 0);
      @(negedge clk);
      chk("trap_err_end", err, 0);
      chk("trap_ready_back", instr_ready, 1);
      chk("trap_no_pulse2", res_vld, 0);
    end else begin
      chk("issue_en", alu_en, 1);
      chk("issue_op", alu_op, op);
      chk("issue_in1", alu_in1, a);
      chk("issue_in2", alu_in2, b);
      chk("issue_no_pulse", res_vld, 0);
      chk("issue_busy", instr_ready, 0);
      chk("issue_no_err", err, 0);
      @(negedge clk);
      chk("wb_pulse", res_vld, 1);
      chk("wb_dst", res_dst, dst);
      chk("wb_val", res_val, r);
      chk("wb_en_low", alu_en, 0);
      chk("wb_busy", instr_ready, 0);
      m[dst] = r;
      @(negedge clk);
      chk("wb_pulse_end", res_vld, 0);
      chk("wb_ready_back", instr_ready, 1);
      chk("op_hold", alu_op, op);
      chk("in1_hold", alu_in1, a);
      chk("res_hold", res_val, r);
    end
  endtask

  initial begin
    int ops [6];
    int sq_op [$];
    int sq_dst [$];
    int sq_s1 [$];
    int sq_s2 [$];
    int sq_imm [$];
    int exp_dst [$];
    int exp_val [$];
    int k, cyc, prev_cyc, prev_gap, pulses, n;
    bit acc_now;

    ops = '{0, 1, 2, 3, 4, 15};
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_en", alu_en, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_vld", res_vld, 0);
    chk("rst_dst", res_dst, 0);
    chk("rst_val", res_val, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: LDI, ADD, SUB, MUL, GT, EQ
    issue(15, 1, 0, 0, 3);
    issue(15, 2, 0, 0, 14);
    issue(0, 3, 1, 2, 0);   // 3 + -2 = 1
    issue(1, 0, 2, 1, 0);   // -2 - 3 = -5 = B
    issue(2, 3, 1, 1, 0);   // 3*3 = 9 (wraps into the sign bit)
    issue(4, 0, 2, 1, 0);   // -2 > 3 -> 0
    issue(3, 2, 2, 2, 0);   // dst == src1 == src2
    issue(0, 0, 3, 2, 0);   // reads r2 just written above

    // Back-to-back stream with valid held high
    n = 30;
    for (int i = 0; i < n; i++) begin
      sq_op.push_back(ops[$urandom_range(0, 5)]);
      sq_dst.push_back($urandom_range(0, 3));
      sq_s1.push_back($urandom_range(0, 3));
      sq_s2.push_back($urandom_range(0, 3));
      sq_imm.push_back($urandom_range(0, 15));
    end
    k = 0; cyc = 0; prev_cyc = 0; prev_gap = 0; pulses = 0;
    instr_valid = 1'b1;
    instr = {sq_op[0][3:0], sq_dst[0][1:0], sq_s1[0][1:0], sq_s2[0][1:0], sq_imm[0][3:0]};
    while ((k < n || exp_dst.size() > 0) && cyc < 1000) begin
      acc_now = instr_valid && instr_ready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        if (k > 0) chk("stream_gap", cyc - prev_cyc, prev_gap);
        prev_cyc = cyc;
        prev_gap = (sq_op[k] == 15) ? 2 : 3;
        exp_dst.push_back(sq_dst[k]);
        exp_val.push_back(ref_res(sq_op[k], m[sq_s1[k]], m[sq_s2[k]], sq_imm[k]));
        m[sq_dst[k]] = exp_val[$];
        k++;
        if (k < n) begin
          instr = {sq_op[k][3:0], sq_dst[k][1:0], sq_s1[k][1:0], sq_s2[k][1:0], sq_imm[k][3:0]};
        end else begin
          instr_valid = 1'b0;
        end
      end
      if (res_vld) begin
        pulses++;
        if (exp_dst.size() > 0) begin
          chk("stream_dst", res_dst, exp_dst.pop_front());
          chk("stream_val", res_val, exp_val.pop_front());
        end
      end
    end
    chk("stream_timeout", (cyc < 1000) ? 1 : 0, 1);
    chk("stream_pulses", pulses, n);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ISSUE aborts the instruction
    issue(15, 3, 0, 0, 5);
    issue(15, 1, 0, 0, 2);
    instr_valid = 1'b1;
    instr = {4'd0, 2'd3, 2'd1, 2'd1, 4'd0};
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort_in_issue", alu_en, 1);
    rst = 1'b1;
    #1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_en", alu_en, 0);
    chk("abort_vld", res_vld, 0);
    chk("abort_val", res_val, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    chk("post_rst_ready", instr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_pulse", res_vld, 0);
    end
    issue(0, 0, 3, 3, 0);   // r3 must read 0

    // Undefined opcode 7: trapped or issued depending on build
    issue(15, 2, 0, 0, 6);
    issue(15, 3, 0, 0, 3);
    issue(15, 1, 0, 0, 9);
    issue(7, 1, 2, 3, 0);
    issue(0, 0, 1, 1, 0);   // reveals r1 via alu_in1/alu_in2

    // Randomized single issues over the whole opcode space
    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
